// File: rtl/mul_seq_pkg.sv
// Shared types and defaults for the sequential repeated-addition multiplier.
package mul_seq_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/mul_seq_cnt.sv
// Loadable down-counter holding the remaining number of additions.
module mul_seq_cnt
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             dec,
  input  logic [WIDTH-1:0] d,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = d;
    end else if (dec) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mul_seq.sv
// Sequential multiplier: p = a*b by adding a once per cycle, b times.
// Define MUL_SEQ_EARLY_EXIT_EN to skip RUN when either operand is zero.
module mul_seq
  import mul_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] p,
  output logic               busy,
  output logic               done
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic               cnt_load;
  logic               cnt_dec;
  logic               cnt_zero;

  mul_seq_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .load (cnt_load),
    .dec  (cnt_dec),
    .d    (b),
    .zero (cnt_zero)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    acc_d    = acc_q;
    p_d      = p_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d      = a;
          acc_d    = '0;
          cnt_load = 1'b1;
          state_d  = RUN;
`ifdef MUL_SEQ_EARLY_EXIT_EN
          if ((a == '0) || (b == '0)) begin
            p_d     = '0;
            state_d = DONE;
          end
`endif
        end
      end
      RUN: begin
        if (!cnt_zero) begin
          acc_d   = acc_q + {{WIDTH{1'b0}}, a_q};
          cnt_dec = 1'b1;
        end else begin
          p_d     = acc_q;
          state_d = DONE;
        end
      end
      DONE: begin
        // start is deliberately not looked at here; the next request waits for IDLE
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      acc_q   <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      acc_q   <= acc_d;
      p_q     <= p_d;
    end
  end

  assign p    = p_q;
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq; expected product and done latency queued per request.
module tb_mul_seq;

  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [2*W-1:0] p;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [2*W-1:0] p;
    int             lat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  mul_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .p     (p),
    .busy  (busy),
    .done  (done)
  );

  function automatic int exp_lat(input int av, input int bv);
`ifdef MUL_SEQ_EARLY_EXIT_EN
    if (av == 0 || bv == 0) return 1;
`endif
    return bv + 2;
  endfunction

  // Called at a negedge; returns at the negedge following the sampling edge.
  task automatic issue(input int av, input int bv);
    exp_t e;
    e.p   = (2*W)'(av * bv);
    e.lat = exp_lat(av, bv);
    sb.push_back(e);
    a     = W'(av);
    b     = W'(bv);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Latency k means done is seen at the k-th negedge after the sampling edge.
  task automatic wait_done(input int budget, output int lat);
    lat = -1;
    for (int k = 1; k <= budget; k++) begin
      if (done === 1'b1) begin
        lat = k;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy actual=%b expected=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done actual=%b expected=0", done); end
    checks++; if (p !== '0) begin errors++; $display("FAIL reset_p actual=%0d expected=0", p); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    exp_t e;
    int   lat;
    issue(3, 5);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy actual=%b expected=1", busy); end
    wait_done(40, lat);
    e = sb.pop_front();
    checks++; if (lat != 7 || lat != e.lat) begin errors++; $display("FAIL basic_latency actual=%0d expected=7", lat); end
    checks++; if (p !== 8'd15) begin errors++; $display("FAIL basic_p actual=%0d expected=15", p); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width actual=%b expected=0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle actual=%b expected=0", busy); end
    a = 4'd9; b = 4'd9;
    repeat (2) @(negedge clk);
    checks++; if (p !== e.p) begin errors++; $display("FAIL basic_p_hold actual=%0d expected=%0d", p, e.p); end
  endtask

  task automatic test_ops(input string name, input int av, input int bv);
    exp_t e;
    int   lat;
    issue(av, bv);
    wait_done(40, lat);
    e = sb.pop_front();
    checks++; if (lat != e.lat) begin errors++; $display("FAIL %s_latency actual=%0d expected=%0d", name, lat, e.lat); end
    checks++; if (p !== e.p) begin errors++; $display("FAIL %s_p actual=%0d expected=%0d", name, p, e.p); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL %s_done_width actual=%b expected=0", name, done); end
  endtask

  task automatic test_ignore();
    exp_t e;
    int   first;
    int   pulses;
    first  = -1;
    pulses = 0;
    issue(2, 4);
    for (int k = 1; k <= 14; k++) begin
      if (k == 2) begin
        a = 4'd7; b = 4'd7; start = 1'b1;
      end else if (k == 3) begin
        start = 1'b0;
      end
      if (done === 1'b1) begin
        pulses++;
        if (first < 0) begin
          first = k;
          e = sb.pop_front();
          checks++; if (p !== e.p) begin errors++; $display("FAIL ignore_p actual=%0d expected=%0d", p, e.p); end
        end
      end
      @(negedge clk);
    end
    checks++; if (first != exp_lat(2, 4)) begin errors++; $display("FAIL ignore_latency actual=%0d expected=%0d", first, exp_lat(2, 4)); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL ignore_pulses actual=%0d expected=1", pulses); end
  endtask

  task automatic test_rst_mid();
    int pulses;
    pulses = 0;
    issue(6, 6);
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy actual=%b expected=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done actual=%b expected=0", done); end
    checks++; if (p !== '0) begin errors++; $display("FAIL rstmid_p actual=%0d expected=0", p); end
    for (int k = 0; k < 12; k++) begin
      if (done === 1'b1) pulses++;
      @(negedge clk);
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL rstmid_no_done actual=%0d expected=0", pulses); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   hits[$];
    for (int i = 0; i < 3; i++) begin
      e.p   = 8'd2;
      e.lat = 0;
      sb.push_back(e);
    end
    a     = 4'd1;
    b     = 4'd2;
    start = 1'b1;
    @(negedge clk);
    for (int k = 1; k <= 16; k++) begin
      if (done === 1'b1) begin
        hits.push_back(k);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          checks++; if (p !== e.p) begin errors++; $display("FAIL b2b_p actual=%0d expected=%0d", p, e.p); end
        end
      end
      @(negedge clk);
    end
    start = 1'b0;
    checks++; if (hits.size() != 3) begin errors++; $display("FAIL b2b_pulses actual=%0d expected=3", hits.size()); end
    for (int i = 0; i < hits.size() && i < 3; i++) begin
      checks++;
      if (hits[i] != 4 + 5 * i) begin
        errors++; $display("FAIL b2b_spacing actual=%0d expected=%0d", hits[i], 4 + 5 * i);
      end
    end
    sb.delete();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_ops("max", 15, 15);
    test_ops("b_zero", 9, 0);
    test_ops("a_zero", 0, 5);
    test_ops("one", 1, 1);
    test_ignore();
    test_rst_mid();
    test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      test_ops("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)));
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
